gated_bus_arbiter: RTL and testbench
====================================

Name: gated_bus_arbiter

Overview:
Round-robin arbiter that shares one 4-bit gated pass-through port among NREQ requesters. It sequences the port's 6-bit unlock code:
- Code is all-ones while the port is open.
- Code is 0 when the port is closed, which forces the idle pattern 4'b0101.

It sits between requesting producers and the gated output stage. It owns all open/close timing and a per-requester completion handshake.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 4, data width per requester and of gate_data
CW, 6, width of the unlock code
HOLD, 3, cycles the gate stays open per grant (1..15; a value of 0 behaves as 1)
IDLE_PAT, 4'b0101, value driven on gate_data whenever the gate is not open

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level; held high until done or abandon
req_data  input  NREQ*DW  requester data; slice i is bits [i*DW +: DW]
gate_code  output  CW  unlock code to the gated stage; all-ones = open, 0 = closed
gate_data  output  DW  data presented through the gate
grant  output  NREQ  one-hot grant, 0 when idle
done  output  NREQ  one-cycle pulse to the winner on normal completion
busy  output  1  high in ARM, OPEN and CLOSE

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset (synchronous, has priority over everything else in the same cycle):
  - state=IDLE, gate_code=0, gate_data=IDLE_PAT, grant=0, done=0, busy=0.
  - Round-robin pointer ptr=0; hold counter=0.
  - Asserting reset in any state aborts immediately: no done pulse, gate closed on the next edge.
- States: IDLE, ARM, OPEN, CLOSE.
- IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, … wrapping modulo NREQ.
  - Latch its index as win, go to ARM; grant[win]=1 and busy=1 from this edge.
  - No request: stay in IDLE, outputs at reset values.
- ARM (exactly 1 cycle, settling):
  - gate_code=all-ones, gate_data=IDLE_PAT.
  - Load hold counter with max(HOLD,1). Go to OPEN.
- OPEN:
  - gate_code=all-ones; gate_data = req_data slice win, registered from the current input each cycle (one-cycle pipeline).
  - Counter decrements each cycle. OPEN lasts exactly max(HOLD,1) cycles, then goes to CLOSE with completion flagged.
- Abandon: if req[win] is sampled low in ARM or OPEN, go to CLOSE at the next edge with completion not flagged. The remaining hold count is discarded.
- CLOSE (exactly 1 cycle):
  - gate_code=0, gate_data=IDLE_PAT, grant=0.
  - done[win]=1 only if completion is flagged.
  - ptr=(win+1) mod NREQ, updated in both the completed and abandoned cases.
  - Go to IDLE.
- Timing: the gate is never open for two back-to-back grants. At least one CLOSE and one IDLE cycle always separate them (gate_code=0 for ≥2 cycles).
- Latency: req sampled high at edge k in IDLE →
  - grant after edge k
  - gate_code=all-ones after edge k+1
  - first requester data on gate_data after edge k+2
  - done after edge k+1+HOLD+1 (CLOSE). For HOLD=3: done after edge k+5.
- Requests arriving while busy are ignored until IDLE. Simultaneous requests are resolved only by ptr.
- gate_code is only ever 0 or all-ones; no partial codes are ever driven.
- grant is always one-hot or zero, and is never nonzero in IDLE.

Test Plan:
1. Reset held 3 cycles with req=4'b1111 → gate_code=0, gate_data=4'b0101, grant=0, done=0 throughout; after release, first grant=4'b0001.
2. Single req[2] high, req_data slice2=4'hA, HOLD=3:
   - grant=4'b0100 one cycle before gate_code=6'b111111.
   - gate_data=4'hA for exactly 3 cycles, else 4'b0101.
   - done=4'b0100 for 1 cycle; then req dropped → IDLE.
3. req=4'b1111 held continuously → grants cycle 0001,0010,0100,1000,0001, each a full ARM/OPEN(3)/CLOSE sequence; ≥2 closed cycles between each.
4. req[1] dropped in the 2nd OPEN cycle → CLOSE next edge, no done, gate_data returns to 4'b0101; next grant goes to requester 2 if requesting.
5. Reset asserted mid-OPEN → next edge gate_code=0, grant=0, no done; ptr=0, so req[3] and req[0] both high → grant=4'b0001.
6. HOLD=0 build with single req[0] → OPEN lasts exactly 1 cycle; done pulses after edge k+3.

Source files
------------

// File: rtl/gated_bus_arbiter.sv
// Round-robin arbiter sharing one gated pass-through port among NREQ requesters.
// Drives the port's unlock code (all-ones open, zero closed) and a per-requester done pulse.
module gated_bus_arbiter #(
  parameter int            NREQ     = 4,
  parameter int            DW       = 4,
  parameter int            CW       = 6,
  parameter int            HOLD     = 3,
  parameter logic [DW-1:0] IDLE_PAT = DW'(4'b0101)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [CW-1:0]        gate_code,
  output logic [DW-1:0]        gate_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int            PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    HOLD_EFF  = (HOLD < 1) ? 4'd1 : 4'(HOLD);
  localparam logic [CW-1:0] CODE_OPEN = '1;
  localparam logic [CW-1:0] CODE_SHUT = '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [3:0]      r_cnt;
  logic            r_cmpl;
  logic [CW-1:0]   r_code;
  logic [DW-1:0]   r_data;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;

  logic [DW-1:0]   w_slice [NREQ];
  logic [DW-1:0]   w_win_data;
  logic            w_req_win;
  logic            w_any;
  logic [PW-1:0]   w_pick;
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_next_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_slice[g] = req_data[g*DW +: DW];
  end

  assign w_win_data = w_slice[r_win];
  assign w_req_win  = req[r_win];
  assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_next_ptr = (r_win == PW'(NREQ-1)) ? '0 : r_win + 1'b1;

  // First requesting index found scanning upward from the pointer, with wrap.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    w_any  = 1'b0;
    w_pick = r_ptr;
    j      = 0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (!w_any && req[idx]) begin
        w_any  = 1'b1;
        w_pick = idx;
      end
    end
  end

  // Outputs change on the edge that leaves a state, so every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_cmpl  <= 1'b0;
      r_code  <= CODE_SHUT;
      r_data  <= IDLE_PAT;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_pick;
            r_grant <= w_onehot;
            r_busy  <= 1'b1;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (!w_req_win) begin
            r_cmpl  <= 1'b0;
            r_state <= S_CLOSE;
          end else begin
            r_code  <= CODE_OPEN;
            r_data  <= IDLE_PAT;
            r_cnt   <= HOLD_EFF;
            r_state <= S_OPEN;
          end
        end
        S_OPEN: begin
          // A requester that walks away gets the gate shut at once, not stale data.
          if (!w_req_win) begin
            r_code  <= CODE_SHUT;
            r_data  <= IDLE_PAT;
            r_cnt   <= '0;
            r_cmpl  <= 1'b0;
            r_state <= S_CLOSE;
          end else begin
            r_data <= w_win_data;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt <= 4'd1) begin
              r_cmpl  <= 1'b1;
              r_state <= S_CLOSE;
            end
          end
        end
        default: begin
          r_code  <= CODE_SHUT;
          r_data  <= IDLE_PAT;
          r_grant <= '0;
          r_busy  <= 1'b0;
          if (r_cmpl) r_done <= r_grant;
          r_cmpl  <= 1'b0;
          r_ptr   <= w_next_ptr;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_code = r_code;
  assign gate_data = r_data;
  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = r_busy;

  a_code_binary: assert property (@(posedge clk) disable iff (reset)
    (r_code == CODE_SHUT) || (r_code == CODE_OPEN));
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(r_grant));
  a_idle_no_grant: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_IDLE) |-> (r_grant == '0));
  a_done_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(r_done));
  a_closed_data: assert property (@(posedge clk) disable iff (reset)
    (r_code == CODE_SHUT) |-> (r_data == IDLE_PAT));

endmodule

// File: tb/tb_gated_bus_arbiter.sv
// Directed bench for gated_bus_arbiter: a HOLD=3 instance plus a HOLD=0 instance.
module tb_gated_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [5:0]  gate_code;
  logic [3:0]  gate_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  logic [3:0]  req0;
  logic [15:0] req_data0;
  logic [5:0]  gate_code0;
  logic [3:0]  gate_data0;
  logic [3:0]  grant0;
  logic [3:0]  done0;
  logic        busy0;

  int n_checks = 0;
  int n_errors = 0;

  gated_bus_arbiter #(.NREQ(4), .DW(4), .CW(6), .HOLD(3), .IDLE_PAT(4'b0101)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gate_code(gate_code), .gate_data(gate_data), .grant(grant), .done(done), .busy(busy)
  );

  gated_bus_arbiter #(.NREQ(4), .DW(4), .CW(6), .HOLD(0), .IDLE_PAT(4'b0101)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_data(req_data0),
    .gate_code(gate_code0), .gate_data(gate_data0), .grant(grant0), .done(done0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the grant edge k; returns just after the done edge k+5.
  task automatic txn(input logic [3:0] g, input logic [3:0] d);
    check("grant_k", 32'(grant), 32'(g));
    check("busy_k", 32'(busy), 32'd1);
    check("code_k", 32'(gate_code), 32'h00);
    check("data_k", 32'(gate_data), 32'h5);
    tick;
    check("code_arm", 32'(gate_code), 32'h3F);
    check("data_arm", 32'(gate_data), 32'h5);
    check("grant_arm", 32'(grant), 32'(g));
    for (int i = 0; i < 3; i++) begin
      tick;
      check("code_open", 32'(gate_code), 32'h3F);
      check("data_open", 32'(gate_data), 32'(d));
      check("done_open", 32'(done), 32'h0);
    end
    tick;
    check("code_close", 32'(gate_code), 32'h00);
    check("data_close", 32'(gate_data), 32'h5);
    check("grant_close", 32'(grant), 32'h0);
    check("done_close", 32'(done), 32'(g));
    check("busy_close", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_g;
    // slices: 0=C, 1=3, 2=A, 3=8
    req_data  = 16'h8A3C;
    req_data0 = 16'h0006;
    req0      = 4'b0000;
    reset     = 1'b1;
    req       = 4'b1111;

    // Reset held three cycles with every requester asking.
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_code", 32'(gate_code), 32'h00);
      check("rst_data", 32'(gate_data), 32'h5);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;

    // Continuous requests rotate 0001,0010,0100,1000,0001.
    for (int g = 0; g < 5; g++) begin
      tick;
      exp_g = 4'b0001 << (g % 4);
      txn(exp_g, req_data[(g % 4)*4 +: 4]);
      if (g == 4) req = 4'b0000;
    end
    tick;
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_code", 32'(gate_code), 32'h00);

    // Single requester 2.
    req = 4'b0100;
    tick;
    txn(4'b0100, 4'hA);
    req = 4'b0000;
    tick;
    check("idle2_grant", 32'(grant), 32'h0);
    check("idle2_done", 32'(done), 32'h0);

    // Requester 1 abandons in its second OPEN cycle; requester 2 waits.
    req = 4'b0110;
    tick;
    check("ab_grant", 32'(grant), 32'h2);
    tick;
    check("ab_code_arm", 32'(gate_code), 32'h3F);
    tick;
    check("ab_data_open", 32'(gate_data), 32'h3);
    req = 4'b0100;
    tick;
    check("ab_code", 32'(gate_code), 32'h00);
    check("ab_data", 32'(gate_data), 32'h5);
    check("ab_done_a", 32'(done), 32'h0);
    tick;
    check("ab_grant_off", 32'(grant), 32'h0);
    check("ab_done_b", 32'(done), 32'h0);
    check("ab_busy", 32'(busy), 32'd0);
    tick;
    check("ab_next_grant", 32'(grant), 32'h4);

    // Reset in the middle of requester 2's OPEN window.
    tick;
    check("mr_code_arm", 32'(gate_code), 32'h3F);
    tick;
    check("mr_data_open", 32'(gate_data), 32'hA);
    reset = 1'b1;
    req   = 4'b1001;
    tick;
    check("mr_code", 32'(gate_code), 32'h00);
    check("mr_grant", 32'(grant), 32'h0);
    check("mr_done", 32'(done), 32'h0);
    check("mr_data", 32'(gate_data), 32'h5);
    reset = 1'b0;
    tick;
    txn(4'b0001, 4'hC);
    req = 4'b0000;
    tick;
    check("mr_idle", 32'(grant), 32'h0);

    // HOLD=0 instance: gate open for a single cycle.
    req0 = 4'b0001;
    tick;
    check("h0_grant", 32'(grant0), 32'h1);
    check("h0_code_k", 32'(gate_code0), 32'h00);
    tick;
    check("h0_code_arm", 32'(gate_code0), 32'h3F);
    check("h0_data_arm", 32'(gate_data0), 32'h5);
    tick;
    check("h0_data_open", 32'(gate_data0), 32'h6);
    check("h0_done_open", 32'(done0), 32'h0);
    tick;
    check("h0_done", 32'(done0), 32'h1);
    check("h0_code_close", 32'(gate_code0), 32'h00);
    check("h0_grant_close", 32'(grant0), 32'h0);
    req0 = 4'b0000;
    tick;
    check("h0_done_pulse", 32'(done0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
